// File: rtl/port_arbiter.sv
// port_arbiter: round-robin, packet-locked output-port arbiter with credit flow control.
// Define ARB_CREDIT_FLOW_EN for the credit counter; otherwise credit_in acts as a level ready_in.
module port_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] valid,
  input  logic [4:0] tail,
  input  logic       credit_in,
  output logic [4:0] grant,
  output logic [4:0] read_en,
  output logic       valid_out,
  output logic       credit_err
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [2:0] rr_ptr, k, pidx, owner;
  logic [3:0] sum;
  logic [9:0] dbl;
  logic [4:0] rot, pick;
  logic ok, xfer;
  // rotate requests so rr_ptr sits at bit 0, then take the lowest set bit
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[4:0];
    k = '0;
    for (int i = 4; i >= 0; i--) if (rot[i]) k = 3'(i);
    sum = {1'b0, k} + {1'b0, rr_ptr};
    pidx = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
    pick = |req ? 5'(5'b1 << pidx) : 5'b0;
    owner = '0;
    for (int i = 0; i < 5; i++) if (grant[i]) owner = 3'(i);
  end
  assign read_en = (!rst && ok) ? grant & valid : 5'b0;
  assign xfer = |read_en;
  assign valid_out = xfer;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        grant <= pick;
        state <= LOCKED;
      end
    end else if (xfer && |(grant & tail)) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= owner == 3'd4 ? 3'd0 : owner + 3'd1;
    end
  end
`ifdef ARB_CREDIT_FLOW_EN
  logic [CNT_W-1:0] credits;
  assign ok = credits != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CNT_W'(FIFO_DEPTH);
      credit_err <= 1'b0;
    end else if (xfer && !credit_in) begin
      credits <= credits - 1'b1;
    end else if (credit_in && !xfer) begin
      if (credits == CNT_W'(FIFO_DEPTH)) credit_err <= 1'b1;
      else credits <= credits + 1'b1;
    end
  end
`else
  assign ok = credit_in;
  assign credit_err = 1'b0;
`endif
endmodule
